// File: rtl/pkt_cls_pkg.sv
// rtl/pkt_cls_pkg.sv - shared FSM states, sync word and default class tables for packet_classifier
package pkt_cls_pkg;

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_RECV = 2'd1,
      ST_EVAL = 2'd2
   } pkt_state_e;

   localparam logic [7:0] SYNC_WORD = 8'b1010_1011;

   localparam int NUM_DEF_CLASS = 8;

   // Classes 1 (ssh), 2 (telnet) and 7 keep per-session tables
   localparam logic [NUM_DEF_CLASS-1:0] TRACK_MASK = 8'b1000_0110;

   function automatic logic [15:0] class_port(input int idx);
      case (idx)
         0:       return 16'd20;
         1:       return 16'd22;
         2:       return 16'd23;
         3:       return 16'd25;
         4:       return 16'd161;
         5:       return 16'd443;
         6:       return 16'd563;
         7:       return 16'd23399;
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic class_tracked(input int idx);
      if (idx < 0 || idx >= NUM_DEF_CLASS) return 1'b0;
      return TRACK_MASK[idx[2:0]];
   endfunction

endpackage

// File: rtl/sess_cam.sv
// rtl/sess_cam.sv - session-id table: parallel lookup, insert into lowest free slot, full flag
module sess_cam #(
   parameter int DEPTH = 4,
   parameter int KEY_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key,
   input  logic             insert,
   output logic             hit,
   output logic             full
);

   logic [KEY_W-1:0] entry [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] free_oh;

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (entry[i] == key)) hit = 1'b1;
      end
   end

   assign full    = &valid;
   // Lowest clear bit of valid, as a one-hot slot select
   assign free_oh = ~valid & (valid + 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else if (insert && !hit && !full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (free_oh[i]) begin
               entry[i] <= key;
               valid[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/packet_classifier.sv
// rtl/packet_classifier.sv - serial sync-framed packet classifier with per-port-class counters
// Per-class session tracking is built only when PKT_SESS_TRACK_EN is defined.
module packet_classifier
   import pkt_cls_pkg::*;
#(
   parameter int NUM_CLASS  = 8,
   parameter int PORT_W     = 16,
   parameter int SESS_W     = 8,
   parameter int CNT_W      = 8,
   parameter int PKT_LEN    = 256,
   parameter int PORT_OFS   = 64,
   parameter int SESS_OFS   = 136,
   parameter int SESS_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_in,
   input  logic                       data_valid,
   output logic [31:0]                total_cnt,
   output logic [NUM_CLASS*CNT_W-1:0] class_cnt,
   output logic [CNT_W-1:0]           other_cnt,
   output logic [NUM_CLASS*CNT_W-1:0] sess_cnt,
   output logic [NUM_CLASS-1:0]       sess_ovf,
   output logic                       busy,
   output logic                       pkt_done
);

   localparam int              BC_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PKT_LEN - 1);
   localparam logic [31:0]     PORT_LO  = PORT_OFS;
   localparam logic [31:0]     PORT_HI  = PORT_OFS + PORT_W - 1;

   pkt_state_e           state;
   logic [7:0]           shreg;
   logic [7:0]           shreg_nxt;
   logic [BC_W-1:0]      bit_cnt;
   logic [31:0]          bit_idx;
   logic [PORT_W-1:0]    port_q;
   logic                 sync_hit;
   logic                 in_port;
   logic                 eval;
   logic [NUM_CLASS-1:0] match;
   logic [NUM_CLASS-1:0] win;
   logic                 no_match;

   logic [CNT_W-1:0]     cls_cnt [NUM_CLASS];
   logic [CNT_W-1:0]     oth_cnt;
   logic [31:0]          tot_cnt;

   // Sync is judged on the register value including the bit arriving this cycle
   assign shreg_nxt = {shreg[6:0], data_in};
   assign sync_hit  = data_valid && (shreg_nxt == SYNC_WORD);
   assign bit_idx   = 32'(bit_cnt);
   assign in_port   = (bit_idx >= PORT_LO) && (bit_idx <= PORT_HI);
   assign eval      = (state == ST_EVAL);
   assign busy      = (state != ST_HUNT);
   assign pkt_done  = eval;

   assign total_cnt = tot_cnt;
   assign other_cnt = oth_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_HUNT;
         shreg   <= '0;
         bit_cnt <= '0;
         port_q  <= '0;
      end else begin
         if (data_valid) shreg <= shreg_nxt;
         case (state)
            ST_HUNT: begin
               if (sync_hit) begin
                  state   <= ST_RECV;
                  bit_cnt <= '0;
               end
            end
            ST_RECV: begin
               if (data_valid) begin
                  if (in_port) port_q <= {port_q[PORT_W-2:0], data_in};
                  if (bit_cnt == LAST_BIT) begin
                     state   <= ST_EVAL;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_EVAL: state <= ST_HUNT;
            default: state <= ST_HUNT;
         endcase
      end
   end

`ifdef PKT_SESS_TRACK_EN
   localparam logic [31:0] SESS_LO = SESS_OFS;
   localparam logic [31:0] SESS_HI = SESS_OFS + SESS_W - 1;

   logic [SESS_W-1:0] sess_q;
   logic              in_sess;

   assign in_sess = (bit_idx >= SESS_LO) && (bit_idx <= SESS_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sess_q <= '0;
      end else if ((state == ST_RECV) && data_valid && in_sess) begin
         sess_q <= {sess_q[SESS_W-2:0], data_in};
      end
   end
`endif

   // Lowest matching class index wins
   always_comb begin
      logic found;
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
         if (match[i] && !found) begin
            win[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign no_match = ~|match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tot_cnt <= '0;
         oth_cnt <= '0;
         for (int i = 0; i < NUM_CLASS; i++) cls_cnt[i] <= '0;
      end else if (eval) begin
         tot_cnt <= tot_cnt + 32'd1;
         if (no_match && (oth_cnt != '1)) oth_cnt <= oth_cnt + 1'b1;
         for (int i = 0; i < NUM_CLASS; i++) begin
            if (win[i] && (cls_cnt[i] != '1)) cls_cnt[i] <= cls_cnt[i] + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_CLASS; i++) begin : g_class
      localparam logic [PORT_W-1:0] CLASS_PORT = PORT_W'(class_port(i));

      assign match[i] = (i < NUM_DEF_CLASS) && (port_q == CLASS_PORT);
      assign class_cnt[i*CNT_W +: CNT_W] = cls_cnt[i];

`ifdef PKT_SESS_TRACK_EN
      if (class_tracked(i)) begin : g_trk
         logic             hit;
         logic             full;
         logic [CNT_W-1:0] s_cnt;
         logic             ovf;

         sess_cam #(
            .DEPTH (SESS_DEPTH),
            .KEY_W (SESS_W)
         ) u_cam (
            .clk    (clk),
            .rst    (rst),
            .key    (sess_q),
            .insert (eval && win[i]),
            .hit    (hit),
            .full   (full)
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s_cnt <= '0;
               ovf   <= 1'b0;
            end else if (eval && win[i] && !hit) begin
               if (!full) begin
                  if (s_cnt != '1) s_cnt <= s_cnt + 1'b1;
               end else begin
                  ovf <= 1'b1;
               end
            end
         end

         assign sess_cnt[i*CNT_W +: CNT_W] = s_cnt;
         assign sess_ovf[i]                = ovf;
      end else begin : g_untrk
         assign sess_cnt[i*CNT_W +: CNT_W] = '0;
         assign sess_ovf[i]                = 1'b0;
      end
`else
      assign sess_cnt[i*CNT_W +: CNT_W] = '0;
      assign sess_ovf[i]                = 1'b0;
`endif
   end

   if ((PORT_OFS + PORT_W > PKT_LEN) || (SESS_OFS + SESS_W > PKT_LEN) ||
       (SESS_DEPTH < 1) || (NUM_CLASS < 1) || (PORT_W < 2) || (SESS_W < 2)) begin : g_bad_cfg
      $error("packet_classifier: field placement or sizing outside the payload");
   end

endmodule

// File: tb/tb_packet_classifier.sv
// tb/tb_packet_classifier.sv - randomized self-checking bench for packet_classifier
// Session expectations follow PKT_SESS_TRACK_EN; without it they are constant 0.
module tb_packet_classifier;

   localparam int NC = 8;
   localparam int CW = 8;
   localparam int PL = 256;
   localparam int PO = 64;
   localparam int SO = 136;
   localparam int SD = 4;
`ifdef PKT_SESS_TRACK_EN
   localparam bit TRACK = 1'b1;
`else
   localparam bit TRACK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           data_in = 1'b0;
   logic           data_valid = 1'b0;
   logic [31:0]    total_cnt;
   logic [NC*CW-1:0] class_cnt;
   logic [CW-1:0]  other_cnt;
   logic [NC*CW-1:0] sess_cnt;
   logic [NC-1:0]  sess_ovf;
   logic           busy;
   logic           pkt_done;

   int n_tests = 0;
   int n_fail  = 0;

   int tbl [NC] = '{20, 22, 23, 25, 161, 443, 563, 23399};
   bit trk [NC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   int m_total;
   int m_other;
   int m_cls  [NC];
   int m_scnt [NC];
   bit m_ovf  [NC];
   bit seen   [NC][256];

   always #5 clk = ~clk;

   packet_classifier dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .total_cnt  (total_cnt),
      .class_cnt  (class_cnt),
      .other_cnt  (other_cnt),
      .sess_cnt   (sess_cnt),
      .sess_ovf   (sess_ovf),
      .busy       (busy),
      .pkt_done   (pkt_done)
   );

   function automatic void model_clear();
      m_total = 0;
      m_other = 0;
      for (int i = 0; i < NC; i++) begin
         m_cls[i]  = 0;
         m_scnt[i] = 0;
         m_ovf[i]  = 1'b0;
         for (int s = 0; s < 256; s++) seen[i][s] = 1'b0;
      end
   endfunction

   function automatic void model_pkt(input int port, input int sess);
      int c;
      c = -1;
      m_total++;
      for (int i = 0; i < NC; i++) if (c < 0 && tbl[i] == port) c = i;
      if (c < 0) begin
         if (m_other < 255) m_other++;
         return;
      end
      if (m_cls[c] < 255) m_cls[c]++;
      if (TRACK && trk[c] && !seen[c][sess]) begin
         if (m_scnt[c] < SD) begin
            seen[c][sess] = 1'b1;
            m_scnt[c]++;
         end else begin
            m_ovf[c] = 1'b1;
         end
      end
   endfunction

   task automatic drive_bit(input logic b, input int gap);
      @(negedge clk);
      data_in    = b;
      data_valid = 1'b1;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         data_valid = 1'b0;
         data_in    = 1'($urandom);
      end
   endtask

   // Sends sync plus the first nbits payload bits; a full packet also checks the done pulse.
   task automatic send_packet(input logic [15:0] port, input logic [7:0] sess,
                              input int gap, input int nbits);
      logic       pl [PL];
      logic [7:0] sync;
      sync = 8'hAB;
      for (int i = 0; i < PL; i++) pl[i] = 1'($urandom);
      for (int j = 0; j < 16; j++) pl[PO+j] = port[15-j];
      for (int j = 0; j < 8; j++)  pl[SO+j] = sess[7-j];
      // Zero tail keeps the next sync from matching early in the shift register
      for (int i = PL - 7; i < PL; i++) pl[i] = 1'b0;
      for (int j = 0; j < 8; j++) drive_bit(sync[7-j], gap);
      for (int i = 0; i < nbits; i++) begin
         drive_bit(pl[i], (i == PL - 1) ? 0 : gap);
         if (i == 0) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_recv: got %0b expected 1", busy);
            end
         end
      end
      if (nbits == PL) begin
         @(negedge clk);
         data_valid = 1'b0;
         n_tests++;
         if (pkt_done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pkt_done_pulse: got done=%0b busy=%0b expected 1/1", pkt_done, busy);
         end
         @(negedge clk);
         n_tests++;
         if (pkt_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_done_end: got done=%0b busy=%0b expected 0/0", pkt_done, busy);
         end
         model_pkt(int'(port), int'(sess));
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      data_valid = 1'b0;
      data_in    = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (total_cnt !== 32'd0 || other_cnt !== '0 || class_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_counts: got total=%0d other=%0d class=%0h expected all 0",
                  total_cnt, other_cnt, class_cnt);
      end
      n_tests++;
      if (sess_cnt !== '0 || sess_ovf !== '0 || busy !== 1'b0 || pkt_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got sess=%0h ovf=%0h busy=%0b done=%0b expected all 0",
                  sess_cnt, sess_ovf, busy, pkt_done);
      end
      rst = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_single_443();
      send_packet(16'd443, 8'($urandom), 0, PL);
      n_tests++;
      if (class_cnt[5*CW +: CW] !== CW'(m_cls[5]) || total_cnt !== 32'(m_total)) begin
         n_fail++;
         $display("FAIL single_443: got class5=%0d total=%0d expected %0d/%0d",
                  class_cnt[5*CW +: CW], total_cnt, m_cls[5], m_total);
      end
   endtask

   task automatic test_sessions();
      send_packet(16'd22, 8'd5, 0, PL);
      send_packet(16'd22, 8'd5, 0, PL);
      send_packet(16'd22, 8'd9, 0, PL);
      n_tests++;
      if (class_cnt[1*CW +: CW] !== CW'(m_cls[1])) begin
         n_fail++;
         $display("FAIL sess_class1: got %0d expected %0d", class_cnt[1*CW +: CW], m_cls[1]);
      end
      n_tests++;
      if (sess_cnt[1*CW +: CW] !== CW'(m_scnt[1])) begin
         n_fail++;
         $display("FAIL sess_cnt1: got %0d expected %0d", sess_cnt[1*CW +: CW], m_scnt[1]);
      end
   endtask

   task automatic test_sess_full();
      int base;
      base = $urandom_range(0, 200);
      for (int k = 0; k < 5; k++) send_packet(16'd23, 8'(base + k), 0, PL);
      n_tests++;
      if (sess_cnt[2*CW +: CW] !== CW'(m_scnt[2]) || sess_ovf[2] !== m_ovf[2]) begin
         n_fail++;
         $display("FAIL sess_full2: got cnt=%0d ovf=%0b expected %0d/%0b",
                  sess_cnt[2*CW +: CW], sess_ovf[2], m_scnt[2], m_ovf[2]);
      end
   endtask

   task automatic test_other();
      send_packet(16'd1234, 8'($urandom), 0, PL);
      n_tests++;
      if (other_cnt !== CW'(m_other)) begin
         n_fail++;
         $display("FAIL other_cnt: got %0d expected %0d", other_cnt, m_other);
      end
      for (int i = 0; i < NC; i++) begin
         n_tests++;
         if (class_cnt[i*CW +: CW] !== CW'(m_cls[i])) begin
            n_fail++;
            $display("FAIL other_class%0d: got %0d expected %0d", i, class_cnt[i*CW +: CW], m_cls[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] port;
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 1) == 0) port = 16'(tbl[$urandom_range(0, NC - 1)]);
         else                           port = 16'($urandom);
         send_packet(port, 8'($urandom_range(0, 7)), $urandom_range(0, 1), PL);
      end
      n_tests++;
      if (total_cnt !== 32'(m_total) || other_cnt !== CW'(m_other)) begin
         n_fail++;
         $display("FAIL random_totals: got total=%0d other=%0d expected %0d/%0d",
                  total_cnt, other_cnt, m_total, m_other);
      end
      for (int i = 0; i < NC; i++) begin
         n_tests++;
         if (class_cnt[i*CW +: CW] !== CW'(m_cls[i]) || sess_cnt[i*CW +: CW] !== CW'(m_scnt[i]) ||
             sess_ovf[i] !== m_ovf[i]) begin
            n_fail++;
            $display("FAIL random_class%0d: got cls=%0d sess=%0d ovf=%0b expected %0d/%0d/%0b", i,
                     class_cnt[i*CW +: CW], sess_cnt[i*CW +: CW], sess_ovf[i],
                     m_cls[i], m_scnt[i], m_ovf[i]);
         end
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 260; k++) send_packet(16'd20, 8'($urandom), 0, PL);
      n_tests++;
      if (class_cnt[0 +: CW] !== CW'(m_cls[0]) || m_cls[0] != 255) begin
         n_fail++;
         $display("FAIL saturate_class0: got %0d expected 255 (model %0d)", class_cnt[0 +: CW], m_cls[0]);
      end
      n_tests++;
      if (total_cnt !== 32'(m_total)) begin
         n_fail++;
         $display("FAIL saturate_total: got %0d expected %0d", total_cnt, m_total);
      end
   endtask

   task automatic test_mid_reset();
      send_packet(16'd443, 8'($urandom), 0, 101);
      @(negedge clk);
      data_valid = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      n_tests++;
      if (total_cnt !== 32'd0 || class_cnt !== '0 || other_cnt !== '0 || sess_cnt !== '0 ||
          sess_ovf !== '0 || busy !== 1'b0 || pkt_done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got total=%0d class=%0h other=%0d sess=%0h ovf=%0h busy=%0b expected all 0",
                  total_cnt, class_cnt, other_cnt, sess_cnt, sess_ovf, busy);
      end
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      send_packet(16'd25, 8'($urandom), 0, PL);
      n_tests++;
      if (class_cnt[3*CW +: CW] !== CW'(m_cls[3]) || total_cnt !== 32'(m_total)) begin
         n_fail++;
         $display("FAIL after_reset: got class3=%0d total=%0d expected %0d/%0d",
                  class_cnt[3*CW +: CW], total_cnt, m_cls[3], m_total);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] s;
      s = 8'($urandom);
      send_packet(16'd563, s, 3, PL);
      n_tests++;
      if (class_cnt[6*CW +: CW] !== CW'(m_cls[6]) || total_cnt !== 32'(m_total)) begin
         n_fail++;
         $display("FAIL gap_packet: got class6=%0d total=%0d expected %0d/%0d",
                  class_cnt[6*CW +: CW], total_cnt, m_cls[6], m_total);
      end
      send_packet(16'd563, s, 0, PL);
      n_tests++;
      if (class_cnt[6*CW +: CW] !== CW'(m_cls[6]) || other_cnt !== CW'(m_other)) begin
         n_fail++;
         $display("FAIL gapless_packet: got class6=%0d other=%0d expected %0d/%0d",
                  class_cnt[6*CW +: CW], other_cnt, m_cls[6], m_other);
      end
   endtask

   initial begin
      test_reset();
      test_single_443();
      test_sessions();
      test_sess_full();
      test_other();
      test_random();
      test_saturate();
      test_mid_reset();
      test_gaps();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/packet_classifier.md
PACKET_CLASSIFIER -- requirements
Module: packet_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 8, number of port classes counted.
REQ-002 SHALL have parameter PORT_W, default 16, port field width in bits.
REQ-003 SHALL have parameter SESS_W, default 8, session-id field width in bits.
REQ-004 SHALL have parameter CNT_W, default 8, width of each per-class counter.
REQ-005 SHALL have parameter PKT_LEN, default 256, payload bits per packet after the sync word.
REQ-006 SHALL have parameter PORT_OFS, default 64, payload bit index of the port field MSB.
REQ-007 SHALL have parameter SESS_OFS, default 136, payload bit index of the session-id MSB.
REQ-008 SHALL have parameter SESS_DEPTH, default 4, distinct sessions remembered per tracked class.
REQ-009 SHALL have port clk input 1, the single clock; all logic on its rising edge.
REQ-010 SHALL have port rst input 1, asynchronous, active-high reset.
REQ-011 SHALL have port data_in input 1, serial stream bit, MSB first.
REQ-012 SHALL have port data_valid input 1, qualifies data_in; when low, no bit is consumed.
REQ-013 SHALL have port total_cnt output 32, count of packets completed.
REQ-014 SHALL have port class_cnt output NUM_CLASS*CNT_W, packed per-class packet counts, class 0 in LSBs.
REQ-015 SHALL have port other_cnt output CNT_W, packets matching no class.
REQ-016 SHALL have port sess_cnt output NUM_CLASS*CNT_W, distinct sessions per class.
REQ-017 SHALL have port sess_ovf output NUM_CLASS, sticky flag: new session seen with table full.
REQ-018 SHALL have port busy output 1, high while a packet is being received or evaluated.
REQ-019 SHALL have port pkt_done output 1, one-cycle pulse in the EVAL cycle.

Function
REQ-020 SHALL hold an 8-bit shift register of the last valid bits; sync match is register == 8'b1010_1011.
REQ-021 SHALL implement FSM HUNT -> RECV on sync match with data_valid high; RECV -> EVAL after PKT_LEN valid bits; EVAL -> HUNT unconditionally after one cycle.
REQ-022 SHALL ignore sync patterns while in RECV or EVAL; shift register keeps shifting but match is disregarded.
REQ-023 SHALL count payload bits 0..PKT_LEN-1 with a bit counter incremented only on valid bits in RECV.
REQ-024 SHALL capture port from payload bits PORT_OFS..PORT_OFS+PORT_W-1 and session from SESS_OFS..SESS_OFS+SESS_W-1, MSB first.
REQ-025 SHALL in EVAL compare the port against the class port table; lowest matching index wins; no match increments other_cnt.
REQ-026 SHALL saturate class_cnt, other_cnt and sess_cnt at all-ones; total_cnt wraps modulo 2^32.
REQ-027 SHALL, for a matched class with tracking enabled, increment sess_cnt and insert the session id if it is absent from that class's table and the table is not full.
REQ-028 SHALL set sess_ovf for the class when the id is absent and the table is full; the table is unchanged.
REQ-029 SHALL make all counter updates visible the cycle after EVAL; busy SHALL be high in RECV and EVAL only.
REQ-030 SHALL, when data_valid is low in RECV, freeze the bit counter and captured fields.

Reset
REQ-031 SHALL on rst clear FSM to HUNT, shift register, bit counter, all counters, session tables, sess_ovf, busy and pkt_done to 0, including mid-packet.

Configuration
REQ-032 SHALL compile session tracking only when PKT_SESS_TRACK_EN is defined; without it, sess_cnt and sess_ovf SHALL be constant 0 and no session tables SHALL exist.

Structure
REQ-033 SHALL place the FSM state enum, sync word, and the default class port table (20, 22, 23, 25, 161, 443, 563, 23399) and tracked-class mask (classes 1, 2, 7) in package pkt_cls_pkg.
REQ-034 SHALL implement the per-class session table as sub-module sess_cam (SESS_DEPTH entries, lookup, insert, full).

Verification
REQ-035 Sync, then 256-bit payload with port 443 -> class_cnt[5]=1, total_cnt=1, pkt_done one pulse.
REQ-036 Port 22 packets with session ids 5, 5, 9 -> class_cnt[1]=3, sess_cnt[1]=2.
REQ-037 Five port-23 packets with distinct ids, SESS_DEPTH=4 -> sess_cnt[2]=4, sess_ovf[2]=1.
REQ-038 Port 1234 packet -> other_cnt=1, all class_cnt unchanged; 300 port-20 packets -> class_cnt[0]=255.
REQ-039 rst asserted at payload bit 100 -> all outputs 0, next full packet counted normally; data_valid gaps of 3 cycles -> same result as gapless.
